// File: rtl/jts16_pkg.sv
// Shared definitions for the jts16 tile-layer ROM slots.
package jts16_pkg;

  localparam int CHAR_AW = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_BEAT1,
    ST_FILL
  } slot_state_t;

endpackage

// File: rtl/jts16_rom_tagcache.sv
// Small fully-associative tag cache with round-robin replacement.
module jts16_rom_tagcache #(
  parameter int ENTRIES = 4,
  parameter int TW      = 12,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [TW-1:0] wr_tag,
  input  logic [DW-1:0] wr_data,
  input  logic [TW-1:0] rd_tag,
  output logic          hit,
  output logic [DW-1:0] hit_data
);

  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0] valid;
  logic [TW-1:0]      tags [ENTRIES];
  logic [DW-1:0]      data [ENTRIES];
  logic [PW-1:0]      ptr;

  // flush has priority over a write landing in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      ptr   <= '0;
    end else if (flush) begin
      valid <= '0;
      ptr   <= '0;
    end else if (wr_en) begin
      valid[ptr] <= 1'b1;
      ptr        <= (ptr == PW'(ENTRIES - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      tags[ptr] <= wr_tag;
      data[ptr] <= wr_data;
    end
  end

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tags[i] == rd_tag) begin
        hit      = 1'b1;
        hit_data = data[i];
      end
    end
  end

endmodule

// File: rtl/jts16_char_rom_slot.sv
// Char-layer ROM slot: cache lookup, 2-beat SDRAM refill and client handshake.
module jts16_char_rom_slot
  import jts16_pkg::*;
#(
  parameter int          AW      = 22,
  parameter int unsigned OFFSET  = 0,
  parameter int          ENTRIES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [CHAR_AW-1:0] char_addr,
  output logic [31:0]        char_data,
  output logic               char_ok,
  output logic [AW-1:0]      sdram_addr,
  output logic               sdram_req,
  input  logic               sdram_ack,
  input  logic               sdram_dst,
  input  logic               sdram_rdy,
  input  logic [15:0]        sdram_din
);

  // state    | meaning
  // ST_IDLE  | look up addr_l once it matches char_addr
  // ST_REQ   | sdram_req high, waiting for ack
  // ST_WAIT  | waiting for first beat (dst)
  // ST_BEAT1 | waiting for second beat (rdy)
  // ST_FILL  | write cache, answer client if still on the same address

  slot_state_t        state, state_nx;
  logic [CHAR_AW-1:0] addr_l;
  logic               ok_r;
  logic [11:0]        tag_f;
  logic [15:0]        lo, hi;
  logic               flushed;
  logic               hit;
  logic [31:0]        hit_data;
  logic               addr_same;
  logic               fill_wr;

  assign addr_same = (char_addr == addr_l);
  assign char_ok   = ok_r & addr_same;
  assign sdram_req = (state == ST_REQ);
  assign fill_wr   = (state == ST_FILL) && !flushed;

  jts16_rom_tagcache #(.ENTRIES(ENTRIES), .TW(12), .DW(32)) u_cache (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .wr_en    (fill_wr),
    .wr_tag   (tag_f),
    .wr_data  ({hi, lo}),
    .rd_tag   (addr_l[12:1]),
    .hit      (hit),
    .hit_data (hit_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (addr_same && !hit) state_nx = ST_REQ;
      ST_REQ:   if (sdram_ack) state_nx = ST_WAIT;
      ST_WAIT:  if (sdram_dst) state_nx = ST_BEAT1;
      ST_BEAT1: if (sdram_rdy) state_nx = ST_FILL;
      ST_FILL:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_l     <= '0;
      ok_r       <= 1'b0;
      char_data  <= '0;
      sdram_addr <= '0;
      tag_f      <= '0;
      lo         <= '0;
      hi         <= '0;
      flushed    <= 1'b0;
    end else begin
      addr_l <= char_addr;
      case (state)
        ST_IDLE: begin
          // only act on an address that has been stable for a cycle
          if (addr_same) begin
            if (hit) begin
              char_data <= hit_data;
              ok_r      <= 1'b1;
            end else begin
              ok_r       <= 1'b0;
              sdram_addr <= AW'(OFFSET) + AW'({addr_l[12:1], 1'b0});
              tag_f      <= addr_l[12:1];
              flushed    <= 1'b0;
            end
          end
        end
        ST_WAIT:  if (sdram_dst) lo <= sdram_din;
        ST_BEAT1: if (sdram_rdy) hi <= sdram_din;
        ST_FILL: begin
          if (!flushed && !flush && tag_f == addr_l[12:1]) begin
            char_data <= {hi, lo};
            ok_r      <= 1'b1;
          end
        end
        default: ;
      endcase
      if (!addr_same) ok_r <= 1'b0;
      if (flush) begin
        ok_r <= 1'b0;
        if (state != ST_IDLE) flushed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jts16_char_rom_slot.sv
// Randomized bench for jts16_char_rom_slot against a FIFO-replacement cache model.
module tb_jts16_char_rom_slot;

  localparam int          AW  = 22;
  localparam int unsigned OFF = 32'h10000;
  localparam int          ENT = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush, sdram_ack, sdram_dst, sdram_rdy;
  logic [12:0]   char_addr;
  logic [15:0]   sdram_din;
  logic [31:0]   char_data;
  logic          char_ok, sdram_req;
  logic [AW-1:0] sdram_addr;

  int            checks = 0, failures = 0, req_cnt = 0;
  logic [AW-1:0] last_req;
  bit            ok_seen;
  logic [11:0]   mtag[$];
  logic [31:0]   mdat[$];
  logic [12:0]   pool[6];

  always #5 clk = ~clk;

  jts16_char_rom_slot #(.AW(AW), .OFFSET(OFF), .ENTRIES(ENT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .char_addr(char_addr),
    .char_data(char_data), .char_ok(char_ok), .sdram_addr(sdram_addr),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_dst(sdram_dst),
    .sdram_rdy(sdram_rdy), .sdram_din(sdram_din)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    ok_seen |= char_ok;
  endtask

  function automatic logic [15:0] rom(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a * 22'h2F1D3;
    return t[17:2] ^ 16'h5A5A;
  endfunction

  function automatic logic [AW-1:0] waddr(input logic [12:0] a);
    return AW'(OFF + a);
  endfunction

  function automatic logic [31:0] line(input logic [12:0] a);
    return {rom(waddr(a) + 1'b1), rom(waddr(a))};
  endfunction

  task automatic model_find(input logic [12:0] a, output bit hit, output logic [31:0] d);
    hit = 0; d = '0;
    foreach (mtag[i]) if (mtag[i] == a[12:1]) begin hit = 1; d = mdat[i]; end
  endtask

  task automatic model_fill(input logic [12:0] a, input logic [31:0] d);
    if (mtag.size() == ENT) begin
      void'(mtag.pop_front());
      void'(mdat.pop_front());
    end
    mtag.push_back(a[12:1]);
    mdat.push_back(d);
  endtask

  task automatic do_flush();
    flush = 1; step(); flush = 0;
    mtag.delete(); mdat.delete();
  endtask

  task automatic wait_req(input logic [AW-1:0] exp);
    int n = 0;
    while (!sdram_req && n < 40) begin step(); n++; end
    chk("req_seen", sdram_req, 1);
    chk("req_addr", sdram_addr, exp);
  endtask

  task automatic ack_pulse();
    sdram_ack = 1; step(); sdram_ack = 0;
  endtask

  task automatic beats(input logic [15:0] lo, input logic [15:0] hi);
    sdram_dst = 1; sdram_din = lo; step(); sdram_dst = 0;
    sdram_rdy = 1; sdram_din = hi; step(); sdram_rdy = 0; sdram_din = 16'h0;
  endtask

  // random-latency SDRAM responder including stray rdy/ack the slot must ignore
  task automatic serve_rand(input logic [AW-1:0] a);
    repeat ($urandom_range(0, 2)) step();
    ack_pulse();
    if ($urandom_range(0, 1) == 1) begin
      sdram_rdy = 1; sdram_din = 16'($urandom); step(); sdram_rdy = 0;
    end
    repeat ($urandom_range(0, 2)) step();
    sdram_dst = 1; sdram_din = rom(a); step(); sdram_dst = 0;
    sdram_din = 16'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      sdram_ack = 1; step(); sdram_ack = 0;
    end
    repeat ($urandom_range(0, 2)) step();
    sdram_rdy = 1; sdram_din = rom(a + 1'b1); step(); sdram_rdy = 0;
  endtask

  task automatic access(input logic [12:0] a);
    bit          hit;
    logic [31:0] exp;
    logic [12:0] prev;
    int          c0, lat;
    model_find(a, hit, exp);
    if (!hit) exp = line(a);
    c0 = req_cnt; prev = char_addr;
    char_addr = a; #1;
    if (prev != a) chk("ok_drop", char_ok, 0);
    lat = 0;
    while (!char_ok && lat < 80) begin
      step(); lat++;
      if (sdram_req) begin
        req_cnt++; last_req = sdram_addr;
        serve_rand(sdram_addr);
      end
    end
    chk("ok_seen", char_ok, 1);
    chk("data", char_data, exp);
    if (hit) begin
      chk("hit_lat", lat, (prev != a) ? 2 : 0);
      chk("hit_noreq", req_cnt - c0, 0);
    end else begin
      chk("miss_req", req_cnt - c0, 1);
      chk("miss_addr", last_req, waddr(a));
      model_fill(a, exp);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; flush = 0; sdram_ack = 0; sdram_dst = 0; sdram_rdy = 0;
    sdram_din = 0; char_addr = 13'h0A4;
    repeat (3) step();
    chk("rst_data", char_data, 0);
    chk("rst_ok", char_ok, 0);
    chk("rst_req", sdram_req, 0);
    chk("rst_addr", sdram_addr, 0);
    rst_n = 1;

    // cold miss with fixed beat data
    wait_req(22'h100A4);
    chk("cold_ok_low", char_ok, 0);
    ack_pulse();
    beats(16'h1234, 16'hABCD);
    step();
    chk("cold_ok", char_ok, 1);
    chk("cold_data", char_data, 32'hABCD1234);
    model_fill(13'h0A4, 32'hABCD1234);

    // hit after another fill
    access(13'h1F0);
    access(13'h0A4);

    // address change while the fetch is in WAIT
    do_flush();
    ok_seen = 0;
    wait_req(waddr(13'h0A4));
    ack_pulse();
    char_addr = 13'h0B0;
    beats(rom(waddr(13'h0A4)), rom(waddr(13'h0A4) + 1'b1));
    wait_req(waddr(13'h0B0));
    chk("mid_ok_low", ok_seen, 0);
    ack_pulse();
    beats(rom(waddr(13'h0B0)), rom(waddr(13'h0B0) + 1'b1));
    step();
    chk("mid_ok", char_ok, 1);
    chk("mid_data", char_data, line(13'h0B0));
    model_fill(13'h0A4, line(13'h0A4));
    model_fill(13'h0B0, line(13'h0B0));
    access(13'h0A4);

    // replacement: five distinct lines into four entries
    do_flush();
    begin
      logic [12:0] ra[5];
      ra[0] = 13'h100; ra[1] = 13'h204; ra[2] = 13'h308; ra[3] = 13'h40C; ra[4] = 13'h510;
      for (int i = 0; i < 5; i++) access(ra[i]);
      for (int i = 1; i < 5; i++) access(ra[i]);
      access(ra[0]);
    end

    // flush while in BEAT1: nothing may be cached
    do_flush();
    char_addr = 13'h600;
    wait_req(waddr(13'h600));
    ack_pulse();
    sdram_dst = 1; sdram_din = rom(waddr(13'h600)); step(); sdram_dst = 0;
    flush = 1; step(); flush = 0;
    sdram_rdy = 1; sdram_din = rom(waddr(13'h600) + 1'b1); step(); sdram_rdy = 0;
    step();
    chk("flush_ok", char_ok, 0);
    mtag.delete(); mdat.delete();
    access(13'h600);

    // random traffic over a small address pool
    for (int i = 0; i < 6; i++) pool[i] = 13'($urandom_range(0, 4095) << 1);
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 9) == 0) do_flush();
      access(pool[$urandom_range(0, 5)]);
      repeat ($urandom_range(0, 2)) step();
    end

    // reset while waiting for the first beat
    do_flush();
    char_addr = 13'h0C8;
    wait_req(waddr(13'h0C8));
    ack_pulse();
    rst_n = 0; step();
    chk("wrst_data", char_data, 0);
    chk("wrst_ok", char_ok, 0);
    chk("wrst_req", sdram_req, 0);
    chk("wrst_addr", sdram_addr, 0);
    rst_n = 1;
    sdram_dst = 1; sdram_din = 16'hFFFF; step(); sdram_dst = 0;
    sdram_rdy = 1; sdram_din = 16'hEEEE; step(); sdram_rdy = 0;
    chk("stray_data", char_data, 0);
    chk("stray_ok", char_ok, 0);
    mtag.delete(); mdat.delete();
    access(13'h0C8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
